fpu_req_arbiter: RTL

- Shares one FPU instance (fpnew, FP16 datapath) between NUM_REQ requesters.
- Each requester has its own valid/ready request channel and response channel.
- The block grants requests round-robin, tags each issued operation with the requester ID and caps in-flight operations.
- Returned results are routed back to the requester named by the tag.
- Sits between the per-requester operand sources and the FPU wrapper's handshake port.

---
 rtl/fpu_arb_pkg.sv | 34 +++
 rtl/fpu_req_arbiter_rr_arbiter.sv | 30 +++
 rtl/fpu_req_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the FPU request arbiter.
// Operation and rounding encodings mirror fpnew_pkg (FP16 datapath).
package fpu_arb_pkg;

    localparam int STATUS_W         = 5;
    localparam int PKG_DWIDTH       = 16;
    localparam int PKG_NUM_OPERANDS = 3;
    localparam int PKG_OP_W         = 4;

    // fpnew operation encodings used by requesters
    localparam logic [PKG_OP_W-1:0] OP_FMADD = 4'd0;
    localparam logic [PKG_OP_W-1:0] OP_ADD   = 4'd2;
    localparam logic [PKG_OP_W-1:0] OP_MUL   = 4'd3;

    // fpnew rounding mode: round to nearest, ties to even
    localparam logic [2:0] RND_RNE = 3'd0;

    typedef struct packed {
        logic [PKG_NUM_OPERANDS-1:0][PKG_DWIDTH-1:0] operands;
        logic [PKG_OP_W-1:0]                         op;
        logic [2:0]                                  rnd;
    } fpu_req_t;

    typedef struct packed {
        logic [PKG_DWIDTH-1:0] result;
        logic [STATUS_W-1:0]   status;
    } fpu_resp_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fpu_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N    = 2,
    parameter int ID_W = 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            grant_valid
);

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'(idx);
                grant[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_req_arbiter.sv
// Round-robin arbiter sharing one FPU between NUM_REQ requesters, with
// tag-based response routing and an in-flight operation cap.
// Optional performance counters: define FPU_ARB_PERF_CNT_EN.
module fpu_req_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int DWIDTH       = 16,
    parameter int NUM_OPERANDS = 3,
    parameter int OP_W         = 4,
    parameter int MAX_OUTST    = 4,
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NUM_REQ-1:0]                     req_valid_i,
    output logic [NUM_REQ-1:0]                     req_ready_o,
    input  logic [NUM_REQ*NUM_OPERANDS*DWIDTH-1:0] req_operands_i,
    input  logic [NUM_REQ*OP_W-1:0]                req_op_i,
    input  logic [NUM_REQ*3-1:0]                   req_rnd_i,
    output logic [NUM_REQ-1:0]                     resp_valid_o,
    input  logic [NUM_REQ-1:0]                     resp_ready_i,
    output logic [DWIDTH-1:0]                      resp_result_o,
    output logic [STATUS_W-1:0]                    resp_status_o,
    output logic                                   fpu_in_valid_o,
    input  logic                                   fpu_in_ready_i,
    output logic [NUM_OPERANDS*DWIDTH-1:0]         fpu_operands_o,
    output logic [OP_W-1:0]                        fpu_op_o,
    output logic [2:0]                             fpu_rnd_o,
    output logic [ID_W-1:0]                        fpu_tag_o,
    input  logic                                   fpu_out_valid_i,
    output logic                                   fpu_out_ready_o,
    input  logic [DWIDTH-1:0]                      fpu_result_i,
    input  logic [STATUS_W-1:0]                    fpu_status_i,
    input  logic [ID_W-1:0]                        fpu_tag_i,
`ifdef FPU_ARB_PERF_CNT_EN
    output logic [NUM_REQ*16-1:0]                  grant_cnt_o,
    output logic [15:0]                            stall_cnt_o,
`endif
    output logic                                   busy_o,
    output logic                                   err_o
);

    localparam int OPS_W = NUM_OPERANDS * DWIDTH;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    arb_state_e          state, state_nxt;
    logic [ID_W-1:0]     rr_ptr, locked_id, grant_id, pick_id;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic                pick_valid, in_valid, tag_ok, req_hs, resp_hs;
    logic [CNT_W-1:0]    outst_cnt;
    logic                err_q;

    rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_rr (
        .req         (req_valid_i),
        .ptr         (rr_ptr),
        .grant       (pick_onehot),
        .grant_id    (pick_id),
        .grant_valid (pick_valid)
    );

    // Next state and request-side valid; a HOLD always runs to its handshake.
    always_comb begin
        state_nxt = state;
        in_valid  = 1'b0;
        grant_id  = locked_id;
        unique case (state)
            IDLE: begin
                if (outst_cnt < CNT_W'(MAX_OUTST) && pick_valid) begin
                    in_valid = 1'b1;
                    grant_id = pick_id;
                    if (!fpu_in_ready_i) state_nxt = HOLD;
                end
            end
            HOLD: begin
                in_valid = 1'b1;
                if (fpu_in_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fpu_in_valid_o = in_valid & rst_ni;
    assign req_hs         = fpu_in_valid_o & fpu_in_ready_i;
    assign fpu_operands_o = req_operands_i[grant_id*OPS_W +: OPS_W];
    assign fpu_op_o       = req_op_i[grant_id*OP_W +: OP_W];
    assign fpu_rnd_o      = req_rnd_i[grant_id*3 +: 3];
    assign fpu_tag_o      = grant_id;

    // Zero-latency ready pass-through to the granted requester.
    always_comb begin
        req_ready_o = '0;
        if (req_hs) req_ready_o[grant_id] = 1'b1;
    end

    // Route results by tag; an out-of-range tag is swallowed.
    always_comb begin
        tag_ok          = (int'(fpu_tag_i) < NUM_REQ);
        resp_valid_o    = '0;
        fpu_out_ready_o = rst_ni;
        if (tag_ok) begin
            resp_valid_o[fpu_tag_i] = fpu_out_valid_i & rst_ni;
            fpu_out_ready_o         = resp_ready_i[fpu_tag_i] & rst_ni;
        end
    end

    assign resp_hs       = fpu_out_valid_i & fpu_out_ready_o;
    assign resp_result_o = fpu_result_i;
    assign resp_status_o = fpu_status_i;
    assign busy_o        = (outst_cnt != '0) | fpu_in_valid_o;
    assign err_o         = err_q;

    // Arbiter state, pointer, in-flight counter and sticky error.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_ni) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            locked_id <= '0;
            outst_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == HOLD) locked_id <= grant_id;
            if (req_hs)
                rr_ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
            unique case ({req_hs, resp_hs})
                2'b10:   outst_cnt <= outst_cnt + 1'b1;
                2'b01:   if (outst_cnt != '0) outst_cnt <= outst_cnt - 1'b1;
                default: ;
            endcase
            if ((resp_hs && !req_hs && outst_cnt == '0) || (fpu_out_valid_i && !tag_ok))
                err_q <= 1'b1;
        end
    end

`ifdef FPU_ARB_PERF_CNT_EN
    logic [NUM_REQ-1:0][15:0] grant_cnt;
    logic [15:0]              stall_cnt;

    // Saturating per-requester grant counters and FPU back-pressure counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (req_hs && grant_cnt[grant_id] != 16'hFFFF)
                grant_cnt[grant_id] <= grant_cnt[grant_id] + 16'd1;
            if (fpu_in_valid_o && !fpu_in_ready_i && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign grant_cnt_o = grant_cnt;
    assign stall_cnt_o = stall_cnt;
`endif

endmodule
